// File: rtl/character_update_sequencer_pkg.sv
// Shared constants and types for the character update sequencer.
package character_update_sequencer_pkg;

  // Character select values seen by the coordinate register block
  localparam logic [2:0] PACMAN    = 3'd0;
  localparam logic [2:0] GHOST1    = 3'd1;
  localparam logic [2:0] GHOST2    = 3'd2;
  localparam logic [2:0] GHOST3    = 3'd3;
  localparam logic [2:0] GHOST4    = 3'd4;
  localparam int         NUM_CHARS = 5;

  // Direction encoding: bit1 selects the x axis, bit0 selects +STEP
  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  // Default playfield bounds (inclusive) and motion settings
  localparam logic [7:0] X_MIN_DEF     = 8'd2;
  localparam logic [7:0] X_MAX_DEF     = 8'd157;
  localparam logic [7:0] Y_MIN_DEF     = 8'd2;
  localparam logic [7:0] Y_MAX_DEF     = 8'd117;
  localparam logic [7:0] STEP_DEF      = 8'd1;
  localparam logic [7:0] LFSR_SEED_DEF = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CAPT  = 3'd2,
    S_CALC  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  // Clamp a 9-bit stepped coordinate into [lo,hi]. Bit 8 after a
  // subtraction means the value wrapped below zero, i.e. below lo.
  function automatic logic [7:0] clamp_axis(input logic [8:0] v,
                                            input logic       sub,
                                            input logic [7:0] lo,
                                            input logic [7:0] hi);
    logic [7:0] r;
    if (sub && v[8])           r = lo;
    else if (v < {1'b0, lo})   r = lo;
    else if (v > {1'b0, hi})   r = hi;
    else                       r = v[7:0];
    return r;
  endfunction

endpackage

// File: rtl/ghost_dir_lfsr.sv
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, for ghost turns.
module ghost_dir_lfsr
  import character_update_sequencer_pkg::*;
#(
  parameter logic [7:0] SEED = LFSR_SEED_DEF
) (
  input  logic       clock_50,
  input  logic       reset_n,
  output logic [7:0] state
);

  // Shift left, feedback from taps 8,6,5,4 (bits 7,5,4,3)
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) state <= SEED;
    else          state <= {state[6:0], state[7] ^ state[5] ^ state[4] ^ state[3]};
  end

endmodule

// File: rtl/character_update_sequencer.sv
// Once-per-frame read/step/clamp/write pass over pacman and ghosts 1-4.
module character_update_sequencer
  import character_update_sequencer_pkg::*;
#(
  parameter logic [7:0] X_MIN     = X_MIN_DEF,
  parameter logic [7:0] X_MAX     = X_MAX_DEF,
  parameter logic [7:0] Y_MIN     = Y_MIN_DEF,
  parameter logic [7:0] Y_MAX     = Y_MAX_DEF,
  parameter logic [7:0] STEP      = STEP_DEF,
  parameter logic [7:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic       clock_50,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic [1:0] pacman_dir,
  input  logic       pacman_move,
  input  logic [7:0] x_rd,
  input  logic [7:0] y_rd,
  output logic [2:0] character_type,
  output logic       readwrite,
  output logic [7:0] x_wr,
  output logic [7:0] y_wr,
  output logic       busy,
  output logic       done,
  output logic       frame_overrun
);

  // Ghost directions, index 0..3 = ghost 1..4
  localparam logic [3:0][1:0] GDIR_RESET = {DIR_UP, DIR_LEFT, DIR_DOWN, DIR_RIGHT};

  state_e          state;
  logic [2:0]      idx;
  logic [7:0]      cur_x, cur_y;
  logic [3:0][1:0] gdir;
  logic [7:0]      lfsr;
  logic            unused_lfsr_hi;

  logic [1:0] gsel, dir;
  logic       is_x, sub, hold, hit;
  logic [7:0] cur_a, lo, hi, clamped, nx, ny;
  logic [8:0] stepped;

  ghost_dir_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clock_50 (clock_50),
    .reset_n  (reset_n),
    .state    (lfsr)
  );

  // Only the low two bits pick a direction
  assign unused_lfsr_hi = ^lfsr[7:2];

  // One movement step on the axis chosen by the current character's direction
  always_comb begin
    gsel    = 2'(idx - 3'd1);
    dir     = (idx == PACMAN) ? pacman_dir : gdir[gsel];
    is_x    = dir[1];
    sub     = ~dir[0];
    cur_a   = is_x ? cur_x : cur_y;
    lo      = is_x ? X_MIN : Y_MIN;
    hi      = is_x ? X_MAX : Y_MAX;
    stepped = sub ? ({1'b0, cur_a} - {1'b0, STEP}) : ({1'b0, cur_a} + {1'b0, STEP});
    clamped = clamp_axis(stepped, sub, lo, hi);
    hit     = ({1'b0, clamped} != stepped);
    nx      = is_x ? clamped : cur_x;
    ny      = is_x ? cur_y : clamped;
    hold    = (idx == PACMAN) && !pacman_move;
    if (hold) begin
      nx  = cur_x;
      ny  = cur_y;
      hit = 1'b0;
    end
  end

  // Pass sequencer; every bus output is registered so it tracks the state
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      idx            <= PACMAN;
      cur_x          <= '0;
      cur_y          <= '0;
      gdir           <= GDIR_RESET;
      character_type <= PACMAN;
      readwrite      <= 1'b0;
      x_wr           <= '0;
      y_wr           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      frame_overrun  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (frame_tick && state != S_IDLE) frame_overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          character_type <= PACMAN;
          readwrite      <= 1'b0;
          if (frame_tick) begin
            idx   <= PACMAN;
            busy  <= 1'b1;
            state <= S_READ;
          end
        end
        S_READ: state <= S_CAPT;
        S_CAPT: begin
          cur_x <= x_rd;
          cur_y <= y_rd;
          state <= S_CALC;
        end
        S_CALC: begin
          x_wr      <= nx;
          y_wr      <= ny;
          readwrite <= 1'b1;
          if (idx != PACMAN && hit) gdir[gsel] <= lfsr[1:0];
          state     <= S_WRITE;
        end
        S_WRITE: begin
          readwrite <= 1'b0;
          if (idx == GHOST4) begin
            character_type <= PACMAN;
            done           <= 1'b1;
            state          <= S_DONE;
          end else begin
            idx            <= idx + 3'd1;
            character_type <= idx + 3'd1;
            state          <= S_READ;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          character_type <= PACMAN;
          readwrite      <= 1'b0;
          busy           <= 1'b0;
          state          <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_character_update_sequencer.sv
// Directed bench: sequencer driving a behavioural coordinate register block.
module tb_character_update_sequencer;

  logic       clock_50 = 1'b0;
  logic       reset_n  = 1'b0;
  logic       frame_tick = 1'b0;
  logic [1:0] pacman_dir = 2'b11;
  logic       pacman_move = 1'b1;
  logic [7:0] x_rd, y_rd;
  logic [2:0] character_type;
  logic       readwrite, busy, done, frame_overrun;
  logic [7:0] x_wr, y_wr;

  int ncmp = 0;
  int nerr = 0;

  always #5 clock_50 = ~clock_50;

  character_update_sequencer dut (
    .clock_50       (clock_50),
    .reset_n        (reset_n),
    .frame_tick     (frame_tick),
    .pacman_dir     (pacman_dir),
    .pacman_move    (pacman_move),
    .x_rd           (x_rd),
    .y_rd           (y_rd),
    .character_type (character_type),
    .readwrite      (readwrite),
    .x_wr           (x_wr),
    .y_wr           (y_wr),
    .busy           (busy),
    .done           (done),
    .frame_overrun  (frame_overrun)
  );

  // ---- coordinate register block model (not reset by reset_n) ----
  logic [7:0] mx [5];
  logic [7:0] my [5];
  logic       pre_en = 1'b0;
  logic [2:0] pre_idx = '0;
  logic [7:0] pre_x = '0, pre_y = '0;
  logic [2:0] wl_t [256];
  logic [7:0] wl_x [256];
  logic [7:0] wl_y [256];
  int         wcnt = 0;

  always @(posedge clock_50) begin
    if (pre_en) begin
      mx[pre_idx] <= pre_x;
      my[pre_idx] <= pre_y;
    end else if (readwrite && character_type < 3'd5) begin
      mx[character_type] <= x_wr;
      my[character_type] <= y_wr;
      wl_t[wcnt[7:0]] <= character_type;
      wl_x[wcnt[7:0]] <= x_wr;
      wl_y[wcnt[7:0]] <= y_wr;
      wcnt <= wcnt + 1;
    end
    x_rd <= (character_type < 3'd5) ? mx[character_type] : 8'd0;
    y_rd <= (character_type < 3'd5) ? my[character_type] : 8'd0;
  end

  // Reference LFSR, same polynomial and seed, reset with the sequencer
  logic [7:0] mlfsr;
  always @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) mlfsr <= 8'hA5;
    else          mlfsr <= {mlfsr[6:0], mlfsr[7] ^ mlfsr[5] ^ mlfsr[4] ^ mlfsr[3]};
  end

  // Bus monitor: a read may never select a nonexistent character
  int mon_bad = 0;
  always @(negedge clock_50) begin
    if (reset_n && !readwrite && character_type > 3'd4) mon_bad <= mon_bad + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Expected single step with clamping, written from the movement rules
  function automatic logic [15:0] step_ref(input int x, input int y, input logic [1:0] d);
    int nx = x;
    int ny = y;
    case (d)
      2'b00: ny = y - 1;
      2'b01: ny = y + 1;
      2'b10: nx = x - 1;
      default: nx = x + 1;
    endcase
    if (d[1]) begin
      if (nx < 2) nx = 2;
      if (nx > 157) nx = 157;
    end else begin
      if (ny < 2) ny = 2;
      if (ny > 117) ny = 117;
    end
    return {nx[7:0], ny[7:0]};
  endfunction

  task automatic preload(input logic [2:0] i, input logic [7:0] x, input logic [7:0] y);
    @(negedge clock_50);
    pre_en = 1'b1; pre_idx = i; pre_x = x; pre_y = y;
    @(negedge clock_50);
    pre_en = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clock_50);
    reset_n = 1'b0;
    repeat (2) @(negedge clock_50);
    reset_n = 1'b1;
  endtask

  // One full pass with timing, write-count and write-order checks.
  // lf_g1 is the LFSR value during ghost1's CALC cycle (E+7).
  task automatic run_pass(input string tag, output int first_w, output logic [7:0] lf_g1);
    bit ok = 1'b1;
    bit ord = 1'b1;
    lf_g1 = '0;
    @(negedge clock_50);
    frame_tick = 1'b1;
    first_w = wcnt;
    @(posedge clock_50); #1;
    frame_tick = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      if (busy !== (k <= 21)) ok = 1'b0;
      if (done !== (k == 21)) ok = 1'b0;
      if (k == 7) lf_g1 = mlfsr;
      @(posedge clock_50); #1;
    end
    chk({tag, " busy/done timing"}, 32'(ok), 32'd1);
    chk({tag, " write count"}, 32'(wcnt - first_w), 32'd5);
    for (int i = 0; i < 5; i++)
      if (wl_t[8'(first_w + i)] !== 3'(i)) ord = 1'b0;
    chk({tag, " write order"}, 32'(ord), 32'd1);
  endtask

  typedef struct {
    logic [7:0] px, py;
    logic [1:0] dir;
    logic       mv;
    logic [7:0] ex, ey;
  } vec_t;

  vec_t vt [10];

  initial begin
    int         fw;
    logic [7:0] lf;
    logic [15:0] e;
    int         dcnt;

    vt[0] = '{8'd2,   8'd2,   2'b00, 1'b1, 8'd2,   8'd2};
    vt[1] = '{8'd2,   8'd2,   2'b11, 1'b0, 8'd2,   8'd2};
    vt[2] = '{8'd157, 8'd50,  2'b11, 1'b1, 8'd157, 8'd50};
    vt[3] = '{8'd100, 8'd117, 2'b01, 1'b1, 8'd100, 8'd117};
    vt[4] = '{8'd2,   8'd60,  2'b10, 1'b1, 8'd2,   8'd60};
    vt[5] = '{8'd0,   8'd0,   2'b10, 1'b1, 8'd2,   8'd0};
    vt[6] = '{8'd255, 8'd200, 2'b11, 1'b1, 8'd157, 8'd200};
    vt[7] = '{8'd50,  8'd60,  2'b01, 1'b1, 8'd50,  8'd61};
    vt[8] = '{8'd50,  8'd60,  2'b00, 1'b1, 8'd50,  8'd59};
    vt[9] = '{8'd157, 8'd117, 2'b01, 1'b0, 8'd157, 8'd117};

    // Power-up contents of the register block, loaded while in reset
    preload(3'd0, 8'd2,  8'd2);
    preload(3'd1, 8'd20, 8'd20);
    preload(3'd2, 8'd40, 8'd40);
    preload(3'd3, 8'd60, 8'd60);
    preload(3'd4, 8'd80, 8'd80);
    #1;
    chk("reset character_type", 32'(character_type), 32'd0);
    chk("reset readwrite", 32'(readwrite), 32'd0);
    chk("reset x_wr", 32'(x_wr), 32'd0);
    chk("reset y_wr", 32'(y_wr), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset frame_overrun", 32'(frame_overrun), 32'd0);
    @(negedge clock_50);
    reset_n = 1'b1;

    // First pass: everyone moves one pixel in its default direction
    pacman_dir = 2'b11; pacman_move = 1'b1;
    run_pass("pass1", fw, lf);
    chk("pass1 pacman", {mx[0], my[0]}, {8'd3,  8'd2});
    chk("pass1 ghost1", {mx[1], my[1]}, {8'd21, 8'd20});
    chk("pass1 ghost2", {mx[2], my[2]}, {8'd40, 8'd41});
    chk("pass1 ghost3", {mx[3], my[3]}, {8'd59, 8'd60});
    chk("pass1 ghost4", {mx[4], my[4]}, {8'd80, 8'd79});

    // Pacman step/clamp/hold table
    for (int i = 0; i < 10; i++) begin
      preload(3'd0, vt[i].px, vt[i].py);
      pacman_dir = vt[i].dir; pacman_move = vt[i].mv;
      run_pass($sformatf("vec%0d", i), fw, lf);
      chk($sformatf("vec%0d pacman stored", i), {mx[0], my[0]}, {vt[i].ex, vt[i].ey});
      chk($sformatf("vec%0d pacman written", i), {wl_x[8'(fw)], wl_y[8'(fw)]}, {vt[i].ex, vt[i].ey});
    end

    // Ghost1 at the right edge: clamped, then turns to LFSR[1:0]
    apply_reset();
    preload(3'd1, 8'd157, 8'd50);
    pacman_dir = 2'b01; pacman_move = 1'b0;
    run_pass("g1edge", fw, lf);
    chk("g1edge ghost1 write", {wl_x[8'(fw + 1)], wl_y[8'(fw + 1)]}, {8'd157, 8'd50});
    e = step_ref(157, 50, lf[1:0]);
    run_pass("g1turn", fw, lf);
    chk("g1turn ghost1 follows new dir", {mx[1], my[1]}, e);

    // Overrun: ticks mid-pass and during DONE are ignored
    apply_reset();
    chk("overrun clear after reset", 32'(frame_overrun), 32'd0);
    dcnt = 0;
    @(negedge clock_50);
    frame_tick = 1'b1;
    fw = wcnt;
    @(posedge clock_50); #1;
    for (int k = 1; k <= 40; k++) begin
      frame_tick = (k == 5 || k == 21);
      if (done === 1'b1) dcnt++;
      @(posedge clock_50); #1;
    end
    frame_tick = 1'b0;
    chk("overrun single pass writes", 32'(wcnt - fw), 32'd5);
    chk("overrun single done pulse", 32'(dcnt), 32'd1);
    chk("overrun flag set", 32'(frame_overrun), 32'd1);
    chk("overrun busy idle", 32'(busy), 32'd0);
    run_pass("post_overrun", fw, lf);
    chk("overrun flag sticky", 32'(frame_overrun), 32'd1);

    // Reset asserted during ghost2's WRITE cycle (E+12)
    preload(3'd2, 8'd70, 8'd70);
    @(negedge clock_50);
    frame_tick = 1'b1;
    @(posedge clock_50); #1;
    frame_tick = 1'b0;
    repeat (11) begin @(posedge clock_50); #1; end
    chk("midreset write in progress", {29'd0, readwrite, character_type}, {28'd0, 1'b1, 3'd2});
    #2 reset_n = 1'b0;
    #1;
    chk("midreset readwrite drops", 32'(readwrite), 32'd0);
    chk("midreset outputs at reset", {character_type, busy, done, frame_overrun, x_wr, y_wr},
        {3'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0});
    @(posedge clock_50); #1;
    chk("midreset ghost2 not written", {mx[2], my[2]}, {8'd70, 8'd70});
    @(negedge clock_50);
    reset_n = 1'b1;
    run_pass("after_midreset", fw, lf);
    chk("after_midreset ghost2 moved", {mx[2], my[2]}, {8'd70, 8'd71});

    chk("no read of type >4", 32'(mon_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/character_update_sequencer.md
Name: character_update_sequencer

Overview:
Bus master for the character coordinate register block: once per frame it walks pacman and ghosts 1-4 in order. For each character it reads the current pixel coordinates, computes one movement step with boundary clamping, and writes the result back. Pacman direction comes from player input; ghost directions are held internally and re-randomised by an LFSR when a ghost hits a boundary. It sits between the frame timer/input logic and the coordinate registers, and reports completion to the renderer.

Parameters:
X_MIN, 2, lowest legal x pixel coordinate
X_MAX, 157, highest legal x pixel coordinate
Y_MIN, 2, lowest legal y pixel coordinate
Y_MAX, 117, highest legal y pixel coordinate
STEP, 1, pixels moved per frame per character (1..15)
LFSR_SEED, 8'hA5, LFSR reset value (must be nonzero)

Ports:
clock_50  in  1  system clock
reset_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse requesting an update pass
pacman_dir  in  2  00 up (y-), 01 down (y+), 10 left (x-), 11 right (x+)
pacman_move  in  1  1 = pacman moves this frame, 0 = pacman holds position
x_rd  in  8  x coordinate returned by the register block
y_rd  in  8  y coordinate returned by the register block
character_type  out  3  character select to register block (0 pacman, 1-4 ghosts)
readwrite  out  1  0 read, 1 write
x_wr  out  8  x coordinate to write
y_wr  out  8  y coordinate to write
busy  out  1  high from tick acceptance through DONE
done  out  1  one-cycle pulse when a pass completes
frame_overrun  out  1  sticky; set when frame_tick arrives while busy

Behaviour:
- Reset values (asynchronous, immediate): state IDLE, character_type=0, readwrite=0, x_wr=0, y_wr=0, busy=0, done=0, frame_overrun=0, LFSR=LFSR_SEED. Ghost directions: g1=11 (right), g2=01 (down), g3=10 (left), g4=00 (up).
- States: IDLE, READ, CAPT, CALC, WRITE, DONE.
- IDLE: drives type=0, readwrite=0. This is a harmless read. Type values 5-7 are never driven with readwrite=0. On frame_tick, set idx=0 and go to READ.
- READ (1 cycle): type=idx, readwrite=0. The register block latches its outputs at this edge.
- CAPT (1 cycle): x_rd/y_rd are valid. Capture them into cur_x/cur_y.
- CALC (1 cycle): compute nx/ny in 9-bit arithmetic.
  - Only the axis selected by the direction changes. Subtract STEP for up/left, add STEP for down/right.
  - Clamp the result to [X_MIN,X_MAX] or [Y_MIN,Y_MAX]. A 9-bit underflow counts as below MIN.
  - Pacman with pacman_move=0: nx=cur_x, ny=cur_y.
  - pacman_dir and pacman_move are sampled in this cycle.
  - Ghost: if clamping changed the stepped value, load that ghost's direction register with LFSR[1:0].
- WRITE (1 cycle): type=idx, readwrite=1, x_wr=nx, y_wr=ny. The write is always issued, even when the position is unchanged. If idx==4 go to DONE; otherwise idx++ and go to READ.
- DONE (1 cycle): done=1, readwrite=0, type=0. Next state is IDLE.
- Latency: tick sampled at edge E. READ starts in cycle E+1, each character takes 4 cycles, and done is high in cycle E+21. busy is high for cycles E+1..E+21.
- frame_tick in any state other than IDLE, including DONE, is ignored and sets frame_overrun. Only reset clears frame_overrun.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1. It advances every cycle regardless of state.
- Reset mid-pass: readwrite drops to 0 asynchronously, so no partial or garbled write is issued. The next pass starts at pacman. The register block's own reset is independent.
- x_wr/y_wr hold their last value outside WRITE.

Decomposition:
- Shared package: character type constants (PACMAN=0, GHOST1..GHOST4=1..4, NUM_CHARS=5), direction encodings, default screen bounds, state encoding.
- One sub-module: ghost_dir_lfsr (8-bit LFSR; inputs clock_50, reset_n; output 8-bit state).
- Clamp/step arithmetic stays inline.

Test Plan:
- Bench setup: the sequencer drives an instance of the coordinate register block.
- Reset, then tick with pacman_move=1, dir=11 -> pacman (3,2), g1 (21,20), g2 (40,41), g3 (59,60), g4 (80,79). Done pulses exactly 21 cycles after the tick edge.
- Pacman at (2,2), dir=00, move=1 -> write (2,2). Pacman_move=0 with dir=11 -> (2,2) unchanged, but the write cycle still occurs.
- Ghost1 preloaded to (157,50) moving right -> writes (157,50); ghost1 direction register equals the LFSR[1:0] value from that CALC cycle; the next pass moves it accordingly.
- frame_tick at cycle E+5 and again during DONE -> both ignored, frame_overrun=1, only one pass executes; a tick in IDLE afterwards starts a normal pass.
- Assert reset_n low during a WRITE of ghost2 -> readwrite=0 in the same cycle, all outputs at reset values. The next tick restarts from character_type=0.
- Monitor across all runs: readwrite=0 with character_type>4 never occurs; busy and done timing matches the latency rule.
